// File: rtl/clk_divider.sv
// Integer refclk divider producing a 50% duty outclk_0 plus a lock flag.
`timescale 1ns/1ps
module clk_divider #(
  parameter int DIVIDE      = 2,
  parameter int LOCK_CYCLES = 16
) (
  input  logic refclk,
  input  logic rst,
  output logic outclk_0,
  output logic locked
);

  localparam int W  = (DIVIDE < 2) ? 1 : $clog2(DIVIDE);
  localparam int LW = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);
  localparam logic [W-1:0]  LAST = W'(DIVIDE - 1);
  localparam logic [W-1:0]  HI   = W'(DIVIDE / 2);
  localparam logic [LW-1:0] LC   = LW'(LOCK_CYCLES);

  if (DIVIDE < 2) begin : g_bad_div
    $error("clk_divider: DIVIDE must be >= 2");
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock
    $error("clk_divider: LOCK_CYCLES must be >= 1");
  end

  logic [1:0]    sync;
  logic          rst_i;
  logic [W-1:0]  cnt;
  logic [W-1:0]  cnt_nx;
  logic          wrap;
  logic          p;
  logic [LW-1:0] lcnt;

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) sync <= 2'b00;
    else      sync <= {sync[0], 1'b1};
  end

  assign rst_i  = sync[1];
  assign wrap   = (cnt == LAST);
  assign cnt_nx = wrap ? '0 : cnt + W'(1);

  always_ff @(posedge refclk or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= LAST;
      p   <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      p   <= (cnt_nx < HI);
    end
  end

  // lock fires on the wrap that makes the (LOCK_CYCLES+1)-th rising edge
  always_ff @(posedge refclk or negedge rst_i) begin
    if (!rst_i) begin
      lcnt   <= '0;
      locked <= 1'b0;
    end else if (wrap) begin
      if (lcnt == LC) locked <= 1'b1;
      else            lcnt   <= lcnt + LW'(1);
    end
  end

  if (DIVIDE % 2 == 1) begin : g_odd
    logic n;
    always_ff @(negedge refclk or negedge rst_i) begin
      if (!rst_i) n <= 1'b0;
      else        n <= p;
    end
    assign outclk_0 = p | n;
  end else begin : g_even
    assign outclk_0 = p;
  end

endmodule

// File: tb/tb_clk_divider.sv
// Bench for clk_divider: three ratios checked against a half-period timeline model.
`timescale 1ns/1ps
module tb_clk_divider;

  logic refclk;
  logic rst;
  logic o [3];
  logic lk [3];

  int errs   = 0;
  int checks = 0;

  int dv [3] = '{2, 4, 5};
  int lv [3] = '{16, 3, 2};

  longint first [3];
  longint lr    [3];
  longint per   [3];
  longint hi    [3];
  longint tl    [3];

  clk_divider #(.DIVIDE(2), .LOCK_CYCLES(16)) u2 (
    .refclk(refclk), .rst(rst), .outclk_0(o[0]), .locked(lk[0]));
  clk_divider #(.DIVIDE(4), .LOCK_CYCLES(3)) u4 (
    .refclk(refclk), .rst(rst), .outclk_0(o[1]), .locked(lk[1]));
  clk_divider #(.DIVIDE(5), .LOCK_CYCLES(2)) u5 (
    .refclk(refclk), .rst(rst), .outclk_0(o[2]), .locked(lk[2]));

  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // h counts refclk half-periods from the first rising edge of outclk_0
  function automatic bit exp_out(int h, int d);
    return (h >= 0) && ((h % (2 * d)) < d);
  endfunction

  function automatic bit exp_lock(int h, int d, int l);
    return (h >= 0) && (h >= 2 * d * l);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_meas
    always @(posedge o[g]) begin
      if (first[g] < 0) first[g] = $time;
      if (lr[g] >= 0) per[g] = $time - lr[g];
      lr[g] = $time;
    end
    always @(negedge o[g]) begin
      if (lr[g] >= 0) hi[g] = $time - lr[g];
    end
    always @(posedge lk[g]) begin
      if (tl[g] < 0) tl[g] = $time;
    end
  end

  task automatic arm();
    for (int i = 0; i < 3; i++) begin
      first[i] = -1;
      lr[i]    = -1;
      per[i]   = -1;
      hi[i]    = -1;
      tl[i]    = -1;
    end
  endtask

  initial begin : compare
    int pc;
    int h;
    bit pos;
    pc = 0;
    h  = -1;
    forever begin
      @(refclk);
      pos = refclk;
      if (!rst) begin
        pc = 0;
        h  = -1;
      end else if (pos) begin
        pc++;
        if (pc == 3)     h = 0;
        else if (pc > 3) h++;
      end else if (pc >= 3) begin
        h++;
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("out_d%0d", dv[i]), o[i], exp_out(h, dv[i]));
        chk($sformatf("lock_d%0d", dv[i]), lk[i],
            exp_lock(h, dv[i], lv[i]));
      end
    end
  end

  initial begin : stim
    longint t_edge;
    int n;
    arm();
    rst = 1'b0;
    repeat (10) @(posedge refclk);
    for (int r = 0; r < 6; r++) begin
      @(posedge refclk);
      t_edge = $time;
      #($urandom_range(2, 8));
      arm();
      rst = 1'b1;
      repeat ($urandom_range(60, 140)) @(posedge refclk);
      #3;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("first_rise_d%0d", dv[i]), first[i] - t_edge, 60);
        chk($sformatf("lock_time_d%0d", dv[i]), tl[i] - first[i],
            longint'(lv[i] * dv[i] * 20));
        chk($sformatf("period_d%0d", dv[i]), per[i], longint'(dv[i] * 20));
        chk($sformatf("high_d%0d", dv[i]), hi[i], longint'(dv[i] * 10));
      end
      n = 0;
      while (!(o[0] && lk[0]) && n < 10) begin
        @(posedge refclk);
        #3;
        n++;
      end
      chk("pre_drop_high_locked", o[0] & lk[0], 1);
      rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("async_out_d%0d", dv[i]), o[i], 0);
        chk($sformatf("async_lock_d%0d", dv[i]), lk[i], 0);
      end
      repeat ($urandom_range(2, 6)) @(posedge refclk);
    end
    #5;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
